// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 UART receiver, LSB first, every bit sampled near its centre.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd sense).
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Parity_Err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        CLEANUP,
        BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            dv_q, dv_d;
    logic            ferr_q, ferr_d;
    logic            par_bad;

`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
    assign par_bad = par_q ^ (^shift_q) ^ PARITY_ODD;
`else
    localparam bit unused_parity_odd = PARITY_ODD;
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) state_d = START;
            end
            // Re-check the line at mid start bit; a short low pulse is a glitch.
            START: begin
                if (cnt_q == MID) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = PARITY;
`else
                    if (idx_q == 3'd7) state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            // Frame error outranks parity error; only a clean frame updates the byte.
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b1;
`endif
                        state_d = CLEANUP;
                    end else begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = CLEANUP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEANUP: state_d = IDLE;
            BREAK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= i_RX_Serial;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign o_RX_DV        = dv_q;
    assign o_RX_Byte      = byte_q;
    assign o_RX_Frame_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_RX_Parity_Err = perr_q;
`else
    assign o_RX_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: scoreboard bench for uart_rx; each frame sent pushes its expected
// outcome (byte, frame error or parity error), a monitor pops on every strobe.
module tb_uart_rx;
    localparam int CPB  = 20;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {EV_DV, EV_FERR, EV_PERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       dv, ferr, perr;
    logic [7:0] rx_byte;
    ev_t        exp_q[$];
    logic [7:0] last_byte = 8'h00;
    int         vectors = 0;
    int         miscompares = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
        .i_Clock        (clk),
        .i_Reset_n      (rst_n),
        .i_RX_Serial    (rx),
        .o_RX_DV        (dv),
        .o_RX_Byte      (rx_byte),
        .o_RX_Frame_Err (ferr),
        .o_RX_Parity_Err(perr)
    );

    always #10 clk = ~clk;

    task automatic bits(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stretch, input logic par_flip);
        ev_t e;
        e.data = d;
        e.kind = !stop_v ? EV_FERR : (PAR_EN && par_flip) ? EV_PERR : EV_DV;
        exp_q.push_back(e);
        bits(1'b0, CPB + stretch);
        for (int i = 0; i < 8; i++) bits(d[i], CPB);
        if (PAR_EN) bits((^d) ^ PODD ^ par_flip, CPB);
        bits(stop_v, CPB);
    endtask

    initial begin
        ev_t      e;
        ev_kind_t got;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                vectors++;
                if (dv !== 1'b0 || ferr !== 1'b0 || perr !== 1'b0 || rx_byte !== 8'h00) begin
                    miscompares++;
                    $display("FAIL reset_outputs: dv=%b ferr=%b perr=%b byte=%02h, required 0 0 0 00", dv, ferr, perr, rx_byte);
                end
                last_byte = 8'h00;
                exp_q.delete();
            end else begin
                if (dv || ferr || perr) begin
                    vectors++;
                    if (int'(dv) + int'(ferr) + int'(perr) > 1) begin
                        miscompares++;
                        $display("FAIL strobe_exclusive: dv=%b ferr=%b perr=%b, required at most one high", dv, ferr, perr);
                    end
                    got = dv ? EV_DV : ferr ? EV_FERR : EV_PERR;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_strobe: kind=%0d byte=%02h, required no strobe", got, rx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        if (got != e.kind || (e.kind == EV_DV && rx_byte !== e.data)) begin
                            miscompares++;
                            $display("FAIL frame_result: kind=%0d byte=%02h, required kind=%0d byte=%02h", got, rx_byte, e.kind, e.data);
                        end
                        if (e.kind == EV_DV) last_byte = e.data;
                    end
                end
                vectors++;
                if (rx_byte !== last_byte) begin
                    miscompares++;
                    $display("FAIL byte_hold: byte=%02h, required %02h", rx_byte, last_byte);
                    last_byte = rx_byte;
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       stop_v;
        int         r;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        bits(1'b1, 2 * CPB);
        send_frame(8'h37, 1'b1, CPB / 8, 1'b0);
        bits(1'b1, 3 * CPB);
        bits(1'b1, 115 * CPB);
        send_frame(8'h19, 1'b1, 0, 1'b0);
        bits(1'b1, CPB);
        bits(1'b0, 3);
        bits(1'b1, 2 * CPB);
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        bits(1'b0, 3 * CPB);
        bits(1'b1, CPB);
        send_frame(8'h5A, 1'b1, 0, 1'b0);
        bits(1'b1, CPB);
        send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 0, 1'b0);
        bits(1'b1, CPB);
        d = 8'hC3;
        bits(1'b0, CPB);
        for (int i = 0; i < 4; i++) bits(d[i], CPB);
        bits(d[4], CPB / 2);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        bits(1'b1, 2 * CPB);
        send_frame(8'h81, 1'b1, 0, 1'b0);
        bits(1'b1, CPB);
        if (PAR_EN) begin
            send_frame(8'h37, 1'b1, 0, 1'b0);
            bits(1'b1, CPB);
            send_frame(8'h37, 1'b1, 0, 1'b1);
            bits(1'b1, CPB);
        end
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                bits(1'b0, int'($urandom_range(1, CPB / 4)));
                bits(1'b1, CPB);
            end else begin
                d      = 8'($urandom);
                stop_v = (r != 1);
                send_frame(d, stop_v, int'($urandom_range(0, CPB * 3 / 10)), r == 2);
                if (!stop_v) bits(1'b0, int'($urandom_range(0, 3)) * CPB);
                bits(1'b1, (stop_v ? 0 : CPB) + int'($urandom_range(0, 2)) * CPB);
            end
        end
        bits(1'b1, CPB);
        for (int i = 0; i < 10 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART serial receiver: deserialises an asynchronous line into bytes.
- Sits between the board RX pin and the byte-stream consumer.
- Pulses a one-cycle valid strobe per good byte and holds the byte until the next good frame.
- Timing derived purely from a clocks-per-bit parameter; LSB first.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200 baud); legal range >= 4.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- i_Clock  input  1  system clock, all logic on rising edge.
- i_Reset_n  input  1  asynchronous active-low reset.
- i_RX_Serial  input  1  asynchronous serial line, idle high.
- o_RX_DV  output  1  one-cycle strobe, good byte on o_RX_Byte.
- o_RX_Byte  output  8  last good received byte, held between frames.
- o_RX_Frame_Err  output  1  one-cycle strobe, stop bit sampled low.
- o_RX_Parity_Err  output  1  one-cycle strobe, parity mismatch; constant 0 without UART_RX_PARITY_EN.

Behaviour:
- Clock and reset (already decided): one clock, i_Clock; reset is asynchronous and active-low on i_Reset_n.
- Reset values:
  - FSM in IDLE, counters 0.
  - o_RX_DV, o_RX_Frame_Err and o_RX_Parity_Err = 0.
  - o_RX_Byte = 0x00.
  - Synchroniser flops = 1.
- Input synchroniser:
  - i_RX_Serial passes through a 2-flop synchroniser; all decisions use the synchronised bit rx_s.
  - Adds 2 cycles of latency.
- Counters:
  - Clock counter width is $clog2(CLKS_PER_BIT).
  - Bit index is 3 bits.
- FSM states and transitions:
  - IDLE: counter = 0. rx_s = 0 -> START.
  - START: count to (CLKS_PER_BIT-1)/2 (mid start bit).
    - rx_s still 0 -> DATA, counter cleared, bit index 0.
    - rx_s = 1 -> glitch rejected, back to IDLE with no outputs.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into shift register bit [index], LSB first.
    - After index 7 -> PARITY (macro on) or STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - Sample 1 and no parity error: o_RX_Byte <= shift register and o_RX_DV = 1 for exactly one cycle, same edge.
    - Sample 0: o_RX_Frame_Err = 1 for one cycle; o_RX_Byte unchanged; no DV -> BREAK.
    - Otherwise -> CLEANUP.
  - CLEANUP: one cycle, strobes deasserted -> IDLE.
  - BREAK: wait until rx_s = 1 -> IDLE. A held-low line is never re-read as a start bit.
- Sampling point:
  - All bits are sampled near the bit centre, referenced from the detected start falling edge.
  - Start bits stretched by up to ~0.4 bit are tolerated; e.g. a 9.68 us start at 8.68 us/bit still decodes correctly.
- Byte completion latency: o_RX_DV rises roughly 0.5 bit plus 3 clocks after the start of the stop bit, i.e. before the stop bit ends.
- Back-to-back frames: a new start edge during or after CLEANUP is accepted. No minimum idle beyond the stop half-bit is needed.
- Reset mid-frame: immediate return to reset values; partial byte discarded.
- Strobes never assert simultaneously with each other.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA: one bit sampled at mid-bit, compared with the XOR of the 8 data bits (even parity), or its inverse if PARITY_ODD = 1.
  - Then STOP is sampled normally.
  - On mismatch with a valid stop bit: o_RX_Parity_Err pulses one cycle, no DV, o_RX_Byte unchanged.
  - Frame error takes precedence over parity error.
- Undefined: 8N1 only; PARITY state absent; o_RX_Parity_Err tied 0.

Test Plan:
- 50 MHz clock, CLKS_PER_BIT = 434, send 0x37 (8.68 us bits, start stretched by 1 us) -> exactly one o_RX_DV pulse; o_RX_Byte = 0x37 and held after the stop bit ends.
- 1 ms idle then send 0x19 -> one DV pulse, o_RX_Byte = 0x19; no frame error.
- 1 us low glitch on an idle line -> no DV, no error; o_RX_Byte keeps its previous value.
- Frame 0xA5 with stop bit driven 0, then line held low 3 bit times -> one o_RX_Frame_Err pulse, no DV, o_RX_Byte unchanged. Next frame 0x5A after line returns high -> DV, 0x5A.
- Back-to-back 0x00 then 0xFF, no idle gap -> two DV pulses, bytes 0x00 then 0xFF.
- Assert i_Reset_n low during data bit 4, release, send 0x81 -> outputs 0 during reset, then a single DV with 0x81.
- With UART_RX_PARITY_EN, PARITY_ODD = 0:
  - 0x37 with parity 1 -> DV.
  - 0x37 with parity 0 -> o_RX_Parity_Err pulse, no DV.
